regfile_wb_arbiter: RTL

- Shares the single register-file write port (we / rd / wr_rd) among N writeback requesters, e.g. ALU, load unit and CSR unit.
- Arbitration is round-robin with a valid/ready handshake per requester.
- The winning write is registered and driven to the register file one cycle after grant.
- The registered write is also exported as a bypass, so readers in the same cycle see data the register file has not yet committed.

---
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port among N
// requesters with round-robin priority, registers the winning write, and
// exports the registered write as a same-cycle bypass entry.
module regfile_wb_arbiter #(
    parameter int N    = 3,
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [N-1:0]      req_valid,
    input  logic [5*N-1:0]    req_rd,
    input  logic [XLEN*N-1:0] req_data,
    output logic [N-1:0]      req_ready,
    output logic              rf_we,
    output logic [4:0]        rf_rd,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [XLEN-1:0]   fwd_data,
    output logic [2:0]        grant_id
);

    localparam int PW = $clog2(N);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [PW-1:0]   ptr_next;

    // Round-robin scan starting at ptr; first valid requester wins, none during reset or hold
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] cand;
        req_ready = '0;
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        sum       = '0;
        cand      = '0;
        if (!reset && !hold) begin
            for (int k = 0; k < N; k++) begin
                sum = {1'b0, ptr} + (PW+1)'(k);
                if (sum >= (PW+1)'(N)) begin
                    sum = sum - (PW+1)'(N);
                end
                cand = sum[PW-1:0];
                if (!gnt_any && req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Mux the winner's destination and data, and work out the pointer that follows it
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_rd   = req_rd[i*5 +: 5];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
        ptr_next = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
    end

    // Register the granted write; x0 writes are consumed but never enable the port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
            ptr      <= '0;
        end else if (gnt_any) begin
            rf_we    <= (sel_rd != 5'd0);
            rf_rd    <= sel_rd;
            rf_wdata <= sel_data;
            grant_id <= 3'(gnt_idx);
            ptr      <= ptr_next;
        end else begin
            rf_we    <= 1'b0;
        end
    end

    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_rd;
    assign fwd_data  = rf_wdata;

endmodule
